// File: rtl/tl_beat_tracker_pkg.sv
// Shared TileLink edge definitions for the beat tracker: opcodes, field widths,
// data-bearing tests and beat-count helpers.
package tl_beat_tracker_pkg;

  localparam int OPCODE_BITS = 3;

  // D-channel opcodes
  localparam logic [OPCODE_BITS-1:0] TL_ACCESS_ACK_DATA = 3'd1;
  localparam logic [OPCODE_BITS-1:0] TL_GRANT           = 3'd4;
  localparam logic [OPCODE_BITS-1:0] TL_GRANT_DATA      = 3'd5;
  // C-channel opcodes
  localparam logic [OPCODE_BITS-1:0] TL_PROBE_ACK_DATA  = 3'd5;
  localparam logic [OPCODE_BITS-1:0] TL_RELEASE_DATA    = 3'd7;

  typedef enum logic {ST_IDLE, ST_ACK} ackState_e;

  function automatic logic hasDataD(input logic [OPCODE_BITS-1:0] opcode);
    return opcode[0];
  endfunction

  function automatic logic hasDataC(input logic [OPCODE_BITS-1:0] opcode);
    return opcode[0];
  endfunction

  function automatic int cntBits(input int dataBits, input int maxLgSize);
    int w;
    w = maxLgSize - $clog2(dataBits / 8);
    return (w < 1) ? 1 : w;
  endfunction

  // Sizes above maxLgSize are clamped rather than rejected.
  function automatic int numBeats(input logic [OPCODE_BITS-1:0] opcode, input int size,
                                  input int dataBits, input int maxLgSize);
    int s;
    int lgBeat;
    s      = (size > maxLgSize) ? maxLgSize : size;
    lgBeat = $clog2(dataBits / 8);
    if (!hasDataD(opcode) || s <= lgBeat) return 1;
    return 1 << (s - lgBeat);
  endfunction

endpackage

// File: rtl/tl_beat_tracker_if.sv
// TileLink D/E plus generic-channel observation bundle for tl_beat_tracker.
// proto_err exists only when TL_BEAT_PROTO_CHECK_EN is defined.
interface tl_beat_tracker_if #(
  parameter int DATA_BITS  = 128,
  parameter int SIZE_BITS  = 4,
  parameter int SINK_BITS  = 3,
  parameter int MAX_LGSIZE = 6,
  parameter int NUM_CH     = 2
) ();
  import tl_beat_tracker_pkg::*;

  localparam int CNT_BITS = cntBits(DATA_BITS, MAX_LGSIZE);

  logic                            d_valid;
  logic                            d_ready_i;
  logic                            d_ready;
  logic [OPCODE_BITS-1:0]          d_opcode;
  logic [SIZE_BITS-1:0]            d_size;
  logic [SINK_BITS-1:0]            d_sink;
  logic [NUM_CH-2:0]               ch_valid;
  logic [NUM_CH-2:0]               ch_ready;
  logic [(NUM_CH-1)*OPCODE_BITS-1:0] ch_opcode;
  logic [(NUM_CH-1)*SIZE_BITS-1:0] ch_size;
  logic [NUM_CH-1:0]               first;
  logic [NUM_CH-1:0]               last;
  logic [NUM_CH-1:0]               done;
  logic [NUM_CH*CNT_BITS-1:0]      count;
  logic                            e_valid;
  logic                            e_ready;
  logic [SINK_BITS-1:0]            e_sink;
`ifdef TL_BEAT_PROTO_CHECK_EN
  logic [NUM_CH-1:0]               proto_err;
`endif

  modport master (
    output d_valid, d_ready_i, d_opcode, d_size, d_sink,
    output ch_valid, ch_ready, ch_opcode, ch_size, e_ready,
    input  d_ready, first, last, done, count, e_valid, e_sink
`ifdef TL_BEAT_PROTO_CHECK_EN
    , input proto_err
`endif
  );

  modport slave (
    input  d_valid, d_ready_i, d_opcode, d_size, d_sink,
    input  ch_valid, ch_ready, ch_opcode, ch_size, e_ready,
    output d_ready, first, last, done, count, e_valid, e_sink
`ifdef TL_BEAT_PROTO_CHECK_EN
    , output proto_err
`endif
  );

endinterface

// File: rtl/tl_beat_counter.sv
// Per-channel beat counter: first/last/done/count from the message beat count.
// With TL_BEAT_PROTO_CHECK_EN, latches opcode/size at the first beat and flags drift.
module tl_beat_counter import tl_beat_tracker_pkg::*; #(
  parameter int DATA_BITS  = 128,
  parameter int SIZE_BITS  = 4,
  parameter int MAX_LGSIZE = 6,
  parameter int CNT_BITS   = cntBits(DATA_BITS, MAX_LGSIZE)
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   fire,
  input  logic [OPCODE_BITS-1:0] opcode,
  input  logic [SIZE_BITS-1:0]   size,
  output logic                   first,
  output logic                   last,
  output logic                   done,
  output logic [CNT_BITS-1:0]    count
`ifdef TL_BEAT_PROTO_CHECK_EN
  , output logic                 protoErr
`endif
);

  logic [CNT_BITS-1:0]    cnt;
  logic [CNT_BITS-1:0]    lastCnt;
  logic [OPCODE_BITS-1:0] msgOpcode;
  logic [SIZE_BITS-1:0]   msgSize;

`ifdef TL_BEAT_PROTO_CHECK_EN
  logic [OPCODE_BITS-1:0] heldOpcode;
  logic [SIZE_BITS-1:0]   heldSize;

  // Later beats are counted against the header the burst started with.
  assign msgOpcode = first ? opcode : heldOpcode;
  assign msgSize   = first ? size   : heldSize;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      heldOpcode <= '0;
      heldSize   <= '0;
      protoErr   <= 1'b0;
    end else if (fire) begin
      if (first) begin
        heldOpcode <= opcode;
        heldSize   <= size;
      end else if (opcode != heldOpcode || size != heldSize) begin
        protoErr <= 1'b1;
      end
    end
  end
`else
  assign msgOpcode = opcode;
  assign msgSize   = size;
`endif

  assign lastCnt = CNT_BITS'(numBeats(msgOpcode, int'(msgSize), DATA_BITS, MAX_LGSIZE) - 1);
  assign first   = (cnt == '0);
  assign last    = (cnt == lastCnt);
  assign done    = fire & last;
  assign count   = cnt;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clock) begin
    if (!reset_n)  cnt <= '0;
    else if (fire) cnt <= last ? '0 : cnt + 1'b1;
  end

endmodule

// File: rtl/tl_beat_tracker.sv
// TileLink multi-beat tracker with E-channel GrantAck generation; channel 0 is D.
// Optional protocol check enabled by defining TL_BEAT_PROTO_CHECK_EN.
module tl_beat_tracker import tl_beat_tracker_pkg::*; #(
  parameter int DATA_BITS  = 128,
  parameter int SIZE_BITS  = 4,
  parameter int SINK_BITS  = 3,
  parameter int MAX_LGSIZE = 6,
  parameter int NUM_CH     = 2
) (
  input logic               clock,
  input logic               reset_n,
  tl_beat_tracker_if.slave  bus
);

  localparam int CNT_BITS = cntBits(DATA_BITS, MAX_LGSIZE);

  logic [NUM_CH-1:0]          fire;
  logic [NUM_CH-1:0]          firstV;
  logic [NUM_CH-1:0]          lastV;
  logic [NUM_CH-1:0]          doneV;
  logic [NUM_CH*CNT_BITS-1:0] countV;
  logic [OPCODE_BITS-1:0]     chOpcode [NUM_CH];
  logic [SIZE_BITS-1:0]       chSize   [NUM_CH];
  logic                       grantDone;
  logic [SINK_BITS-1:0]       ackSink;
  ackState_e                  state;
  ackState_e                  stateNext;

  assign fire[0]     = bus.d_valid & bus.d_ready;
  assign chOpcode[0] = bus.d_opcode;
  assign chSize[0]   = bus.d_size;

  for (genvar i = 1; i < NUM_CH; i++) begin : gen_generic
    assign fire[i]     = bus.ch_valid[i-1] & bus.ch_ready[i-1];
    assign chOpcode[i] = bus.ch_opcode[(i-1)*OPCODE_BITS +: OPCODE_BITS];
    assign chSize[i]   = bus.ch_size[(i-1)*SIZE_BITS +: SIZE_BITS];
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : gen_ch
    tl_beat_counter #(
      .DATA_BITS  (DATA_BITS),
      .SIZE_BITS  (SIZE_BITS),
      .MAX_LGSIZE (MAX_LGSIZE),
      .CNT_BITS   (CNT_BITS)
    ) u_counter (
      .clock    (clock),
      .reset_n  (reset_n),
      .fire     (fire[i]),
      .opcode   (chOpcode[i]),
      .size     (chSize[i]),
      .first    (firstV[i]),
      .last     (lastV[i]),
      .done     (doneV[i]),
      .count    (countV[i*CNT_BITS +: CNT_BITS])
`ifdef TL_BEAT_PROTO_CHECK_EN
      , .protoErr (bus.proto_err[i])
`endif
    );
  end

  assign bus.first = firstV;
  assign bus.last  = lastV;
  assign bus.done  = doneV;
  assign bus.count = countV;

  assign grantDone = doneV[0] & (bus.d_opcode == TL_GRANT || bus.d_opcode == TL_GRANT_DATA);

  always_ff @(posedge clock) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= stateNext;
  end

  // NOTE: a default assignment ahead of the case keeps this block free of latches.
  always_comb begin
    stateNext = state;
    case (state)
      ST_IDLE: if (grantDone)   stateNext = ST_ACK;
      ST_ACK:  if (bus.e_ready) stateNext = ST_IDLE;
      default: stateNext = ST_IDLE;
    endcase
  end

  // D is held off while the ack is outstanding, so a second Grant cannot race it.
  always_comb begin
    bus.e_valid = (state == ST_ACK);
    bus.d_ready = bus.d_ready_i & (state == ST_IDLE);
  end

  always_ff @(posedge clock) begin
    if (!reset_n)                             ackSink <= '0;
    else if (state == ST_IDLE && grantDone)   ackSink <= bus.d_sink;
  end

  assign bus.e_sink = ackSink;

endmodule

// File: tb/tb_tl_beat_tracker.sv
// Directed self-checking bench for tl_beat_tracker (DATA_BITS 128, MAX_LGSIZE 6, NUM_CH 2).
// Define TL_BEAT_PROTO_CHECK_EN to include the protocol-check scenario.
module tb_tl_beat_tracker;
  import tl_beat_tracker_pkg::*;

  logic clock = 1'b0;
  logic reset_n;
  int   checks = 0;
  int   errors = 0;

  always #5 clock = ~clock;

  tl_beat_tracker_if #(
    .DATA_BITS(128), .SIZE_BITS(4), .SINK_BITS(3), .MAX_LGSIZE(6), .NUM_CH(2)
  ) bus ();

  tl_beat_tracker #(
    .DATA_BITS(128), .SIZE_BITS(4), .SINK_BITS(3), .MAX_LGSIZE(6), .NUM_CH(2)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // Count field is 2 bits per channel for this configuration.
  function automatic int cnt0();
    return int'(bus.count[1:0]);
  endfunction

  function automatic int cnt1();
    return int'(bus.count[3:2]);
  endfunction

  task automatic drive_idle();
    bus.d_valid   = 1'b0;
    bus.d_ready_i = 1'b1;
    bus.d_opcode  = 3'd0;
    bus.d_size    = 4'd0;
    bus.d_sink    = 3'd0;
    bus.ch_valid  = 1'b0;
    bus.ch_ready  = 1'b0;
    bus.ch_opcode = 3'd0;
    bus.ch_size   = 4'd0;
    bus.e_ready   = 1'b0;
  endtask

  // Four-beat GrantData on D, then the cycle where the GrantAck appears.
  task automatic grant_burst(input logic [2:0] sink);
    for (int b = 0; b < 4; b++) begin
      @(negedge clock);
      bus.d_valid = 1'b1; bus.d_opcode = 3'd5; bus.d_size = 4'd6; bus.d_sink = sink;
      #1;
      checks++;
      if (cnt0() !== b) begin errors++; $display("FAIL grant count beat %0d: got %0d expected %0d", b, cnt0(), b); end
      checks++;
      if (bus.first[0] !== (b == 0)) begin errors++; $display("FAIL grant first beat %0d: got %0b", b, bus.first[0]); end
      checks++;
      if (bus.last[0] !== (b == 3)) begin errors++; $display("FAIL grant last beat %0d: got %0b", b, bus.last[0]); end
      checks++;
      if (bus.done[0] !== (b == 3)) begin errors++; $display("FAIL grant done beat %0d: got %0b", b, bus.done[0]); end
      checks++;
      if (bus.e_valid !== 1'b0) begin errors++; $display("FAIL grant e_valid early beat %0d: got %0b expected 0", b, bus.e_valid); end
    end
    @(negedge clock);
    bus.d_valid = 1'b0;
    #1;
    checks++;
    if (bus.e_valid !== 1'b1) begin errors++; $display("FAIL grant e_valid: got %0b expected 1", bus.e_valid); end
    checks++;
    if (bus.e_sink !== sink) begin errors++; $display("FAIL grant e_sink: got %0d expected %0d", bus.e_sink, sink); end
    checks++;
    if (bus.d_ready !== 1'b0) begin errors++; $display("FAIL grant d_ready in ack: got %0b expected 0", bus.d_ready); end
  endtask

  task automatic test_reset();
    drive_idle();
    reset_n = 1'b0;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    #1;
    checks++;
    if (bus.count !== 4'd0) begin errors++; $display("FAIL reset count: got %0h expected 0", bus.count); end
    checks++;
    if (bus.first !== 2'b11) begin errors++; $display("FAIL reset first: got %0b expected 11", bus.first); end
    checks++;
    if (bus.last !== 2'b11) begin errors++; $display("FAIL reset last: got %0b expected 11", bus.last); end
    checks++;
    if (bus.done !== 2'b00) begin errors++; $display("FAIL reset done: got %0b expected 00", bus.done); end
    checks++;
    if (bus.e_valid !== 1'b0 || bus.e_sink !== 3'd0) begin
      errors++; $display("FAIL reset e: got valid %0b sink %0d expected 0 0", bus.e_valid, bus.e_sink);
    end
    checks++;
    if (bus.d_ready !== 1'b1) begin errors++; $display("FAIL reset d_ready: got %0b expected 1", bus.d_ready); end
`ifdef TL_BEAT_PROTO_CHECK_EN
    checks++;
    if (bus.proto_err !== 2'b00) begin errors++; $display("FAIL reset proto_err: got %0b expected 00", bus.proto_err); end
`endif
  endtask

  task automatic test_grant_data();
    grant_burst(3'd3);
    @(negedge clock);
    bus.e_ready = 1'b1;
    #1;
    checks++;
    if (bus.e_valid !== 1'b1) begin errors++; $display("FAIL ack hold: got %0b expected 1", bus.e_valid); end
    @(negedge clock);
    bus.e_ready = 1'b0;
    #1;
    checks++;
    if (bus.e_valid !== 1'b0 || bus.d_ready !== 1'b1) begin
      errors++; $display("FAIL ack release: got e_valid %0b d_ready %0b expected 0 1", bus.e_valid, bus.d_ready);
    end
  endtask

  // Ack stalled; an AccessAck waits on D and only fires once the ack drains.
  task automatic test_ack_stall();
    grant_burst(3'd6);
    for (int k = 1; k < 5; k++) begin
      @(negedge clock);
      bus.d_valid = 1'b1; bus.d_opcode = 3'd0; bus.d_size = 4'd6;
      #1;
      checks++;
      if (bus.e_valid !== 1'b1 || bus.d_ready !== 1'b0) begin
        errors++; $display("FAIL stall %0d: got e_valid %0b d_ready %0b expected 1 0", k, bus.e_valid, bus.d_ready);
      end
      checks++;
      if (bus.done[0] !== 1'b0) begin errors++; $display("FAIL stall done %0d: got %0b expected 0", k, bus.done[0]); end
      checks++;
      if (bus.e_sink !== 3'd6) begin errors++; $display("FAIL stall e_sink %0d: got %0d expected 6", k, bus.e_sink); end
    end
    @(negedge clock);
    bus.e_ready = 1'b1;
    #1;
    checks++;
    if (bus.e_valid !== 1'b1 || bus.d_ready !== 1'b0) begin
      errors++; $display("FAIL stall accept: got e_valid %0b d_ready %0b expected 1 0", bus.e_valid, bus.d_ready);
    end
    @(negedge clock);
    bus.e_ready = 1'b0;
    #1;
    checks++;
    if (bus.e_valid !== 1'b0 || bus.d_ready !== 1'b1) begin
      errors++; $display("FAIL stall drain: got e_valid %0b d_ready %0b expected 0 1", bus.e_valid, bus.d_ready);
    end
    checks++;
    if (bus.done[0] !== 1'b1) begin errors++; $display("FAIL stall pending fire: got done %0b expected 1", bus.done[0]); end
    @(negedge clock);
    bus.d_valid = 1'b0;
    #1;
    checks++;
    if (bus.e_valid !== 1'b0) begin errors++; $display("FAIL accessack no ack: got %0b expected 0", bus.e_valid); end
  endtask

  // Single-beat D messages: dataless, small data, boundary size, ReleaseAck.
  task automatic test_single_beat();
    logic [2:0] ops [4]   = '{3'd0, 3'd1, 3'd1, 3'd6};
    logic [3:0] sizes [4] = '{4'd6, 4'd3, 4'd4, 4'd6};
    for (int m = 0; m < 4; m++) begin
      @(negedge clock);
      bus.d_valid = 1'b1; bus.d_opcode = ops[m]; bus.d_size = sizes[m];
      #1;
      checks++;
      if (bus.first[0] !== 1'b1 || bus.last[0] !== 1'b1 || bus.done[0] !== 1'b1 || cnt0() !== 0) begin
        errors++;
        $display("FAIL single beat %0d: got first %0b last %0b done %0b count %0d expected 1 1 1 0",
                 m, bus.first[0], bus.last[0], bus.done[0], cnt0());
      end
      checks++;
      if (bus.e_valid !== 1'b0) begin errors++; $display("FAIL single beat e_valid %0d: got %0b expected 0", m, bus.e_valid); end
    end
    @(negedge clock);
    bus.d_valid = 1'b0;
    #1;
    checks++;
    if (bus.e_valid !== 1'b0) begin errors++; $display("FAIL single beat trailing e_valid: got %0b expected 0", bus.e_valid); end
  endtask

  // AccessAckData size 9 clamps to 64 bytes: 4 beats.
  task automatic test_size_clamp();
    for (int b = 0; b < 4; b++) begin
      @(negedge clock);
      bus.d_valid = 1'b1; bus.d_opcode = 3'd1; bus.d_size = 4'd9;
      #1;
      checks++;
      if (cnt0() !== b || bus.last[0] !== (b == 3)) begin
        errors++; $display("FAIL clamp beat %0d: got count %0d last %0b", b, cnt0(), bus.last[0]);
      end
    end
    @(negedge clock);
    bus.d_valid = 1'b0;
    #1;
    checks++;
    if (bus.e_valid !== 1'b0 || cnt0() !== 0) begin
      errors++; $display("FAIL clamp after: got e_valid %0b count %0d expected 0 0", bus.e_valid, cnt0());
    end
  endtask

  // ReleaseData on channel 1 interleaved with GrantData on D under fixed ready patterns.
  task automatic test_interleave();
    logic [15:0] dPat = 16'b1011_0010_1101_0110;
    logic [15:0] cPat = 16'b0110_1101_0011_1001;
    int dLeft = 4, cLeft = 4, expD = 0, expC = 0;
    int dDones = 0, cDones = 0, ePulses = 0;
    logic dFire, cFire;
    bus.e_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clock);
      bus.d_valid   = (dLeft > 0); bus.d_opcode = 3'd5; bus.d_size = 4'd6; bus.d_sink = 3'd2;
      bus.d_ready_i = dPat[i];
      bus.ch_valid  = (cLeft > 0); bus.ch_opcode = 3'd7; bus.ch_size = 4'd6;
      bus.ch_ready  = cPat[i];
      #1;
      dFire = (dLeft > 0) && dPat[i];
      cFire = (cLeft > 0) && cPat[i];
      checks++;
      if (cnt0() !== expD || cnt1() !== expC) begin
        errors++; $display("FAIL interleave count cycle %0d: got %0d/%0d expected %0d/%0d", i, cnt0(), cnt1(), expD, expC);
      end
      checks++;
      if (bus.done !== {cFire && expC == 3, dFire && expD == 3}) begin
        errors++; $display("FAIL interleave done cycle %0d: got %0b", i, bus.done);
      end
      dDones  += int'(bus.done[0]);
      cDones  += int'(bus.done[1]);
      ePulses += int'(bus.e_valid);
      if (dFire) begin dLeft--; expD = (expD == 3) ? 0 : expD + 1; end
      if (cFire) begin cLeft--; expC = (expC == 3) ? 0 : expC + 1; end
    end
    drive_idle();
    checks++;
    if (dDones !== 1 || cDones !== 1) begin
      errors++; $display("FAIL interleave done pulses: got %0d/%0d expected 1/1", dDones, cDones);
    end
    checks++;
    if (ePulses !== 1) begin errors++; $display("FAIL interleave ack cycles: got %0d expected 1", ePulses); end
  endtask

  // Reset during beat 2 drops the burst; a fresh burst then completes normally.
  task automatic test_reset_mid_burst();
    for (int b = 0; b < 3; b++) begin
      @(negedge clock);
      bus.d_valid = 1'b1; bus.d_opcode = 3'd5; bus.d_size = 4'd6; bus.d_sink = 3'd1;
      if (b == 2) reset_n = 1'b0;
      #1;
      checks++;
      if (cnt0() !== b) begin errors++; $display("FAIL midreset beat %0d: got %0d expected %0d", b, cnt0(), b); end
    end
    @(negedge clock);
    reset_n = 1'b1;
    bus.d_valid = 1'b0;
    #1;
    checks++;
    if (cnt0() !== 0 || bus.e_valid !== 1'b0 || bus.first[0] !== 1'b1) begin
      errors++; $display("FAIL midreset state: got count %0d e_valid %0b first %0b expected 0 0 1", cnt0(), bus.e_valid, bus.first[0]);
    end
    @(negedge clock);
    #1;
    checks++;
    if (bus.e_valid !== 1'b0) begin errors++; $display("FAIL midreset no ack: got %0b expected 0", bus.e_valid); end
    grant_burst(3'd5);
    @(negedge clock);
    bus.e_ready = 1'b1;
    @(negedge clock);
    bus.e_ready = 1'b0;
    #1;
    checks++;
    if (bus.e_valid !== 1'b0) begin errors++; $display("FAIL midreset ack drain: got %0b expected 0", bus.e_valid); end
  endtask

`ifdef TL_BEAT_PROTO_CHECK_EN
  task automatic test_proto_check();
    logic [3:0] sizes [4] = '{4'd6, 4'd5, 4'd6, 4'd6};
    for (int b = 0; b < 4; b++) begin
      @(negedge clock);
      bus.ch_valid = 1'b1; bus.ch_ready = 1'b1; bus.ch_opcode = 3'd7; bus.ch_size = sizes[b];
      #1;
      checks++;
      if (bus.proto_err !== ((b >= 2) ? 2'b10 : 2'b00)) begin
        errors++; $display("FAIL proto_err beat %0d: got %0b", b, bus.proto_err);
      end
      checks++;
      if (cnt1() !== b || bus.done[1] !== (b == 3)) begin
        errors++; $display("FAIL proto count beat %0d: got %0d done %0b", b, cnt1(), bus.done[1]);
      end
    end
    drive_idle();
    repeat (2) @(negedge clock);
    #1;
    checks++;
    if (bus.proto_err !== 2'b10) begin errors++; $display("FAIL proto_err sticky: got %0b expected 10", bus.proto_err); end
  endtask
`endif

  initial begin
    test_reset();
    test_grant_data();
    test_ack_stall();
    test_single_beat();
    test_size_clamp();
    test_interleave();
    test_reset_mid_burst();
`ifdef TL_BEAT_PROTO_CHECK_EN
    test_proto_check();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
